band_mixer: RTL and testbench
=============================

BAND_MIXER -- requirements
Module: band_mixer

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 8, number of band playback streams mixed.
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_BANDS), MAC index width.
REQ-003 SHALL have port clk  input  1  system clock (4.4 MHz); one clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port band_data  input  NUM_BANDS*16  signed samples, band k in bits [16k+15:16k].
REQ-006 SHALL have port band_valid  input  NUM_BANDS  per-band single-cycle sample strobe.
REQ-007 SHALL have port band_gain  input  NUM_BANDS*8  unsigned gain, band k in bits [8k+7:8k]; 128 = unity.
REQ-008 SHALL have port mix_out  output  16  signed mixed sample.
REQ-009 SHALL have port mix_valid  output  1  single-cycle strobe, mix_out new.
REQ-010 SHALL have port overrun  output  1  sticky; band sample overwritten before consumption.

Function
REQ-011 SHALL hold a capture bank: per band, a 16-bit sample register and a pending bit.
REQ-012 SHALL, on an edge with band_valid[k]=1, load band k's sample register from band_data and set pending[k].
REQ-013 SHALL set overrun if band_valid[k]=1 while pending[k] is already 1; the new sample overwrites the old one.
REQ-014 SHALL implement FSM states IDLE, MAC, OUT; reset state IDLE.
REQ-015 SHALL, in IDLE with all pending bits set, do the following on the next edge: copy all samples and all band_gain values into a working bank; clear all pending bits; clear the accumulator; set idx=0; go to MAC.
REQ-016 SHALL, if band_valid[k]=1 on that same edge, leave pending[k] set and capture the new sample; the new valid wins over the clear.
REQ-017 SHALL, in MAC, add working_sample[idx] * {1'b0, working_gain[idx]} (signed 25-bit product) to the accumulator each edge, with idx increasing by 1 each edge.
REQ-018 SHALL make the accumulator 25+$clog2(NUM_BANDS)+1 bits signed, so that it cannot overflow.
REQ-019 SHALL, on the edge that accumulates idx=NUM_BANDS-1, go to OUT.
REQ-020 SHALL, in OUT on the next edge, arithmetic-shift the accumulator right by 7 (floor rounding), saturate to [-32768, 32767], register the result to mix_out, assert mix_valid for exactly one cycle, and return to IDLE.
REQ-021 SHALL give a latency as follows: if edge E0 sets the last pending bit, then E1 enters MAC, E(NUM_BANDS+1) enters OUT, and mix_valid is high in the cycle after E(NUM_BANDS+2), i.e. 10 edges for NUM_BANDS=8.
REQ-022 SHALL keep accepting captures during MAC and OUT; the working bank isolates the in-flight mix from new samples and from band_gain changes.
REQ-023 SHALL, if all pending bits are set upon return to IDLE, start the next mix on the following edge with no extra idle cycles.
REQ-024 SHALL hold mix_out between mix_valid strobes; mix_valid SHALL be 0 in all other cycles.
REQ-025 SHALL accept band_valid bits arriving on different cycles (skew); a mix starts only when every band is pending.
REQ-026 SHALL ensure that with 44.1 kHz strobes at 4.4 MHz (about 99 cycles per period) and NUM_BANDS <= 64, no overrun occurs in normal operation.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force: FSM to IDLE; mix_out to 0; mix_valid to 0; overrun to 0; all pending bits, the accumulator, idx, and the sample and working banks to 0.
REQ-028 SHALL, on reset mid-MAC, discard the partial mix; no mix_valid is produced for it.
REQ-029 SHALL, after rst_n deasserts, require a full set of fresh band_valid strobes before the first mix.

Verification
REQ-030 SHALL cover unity mix: all 8 bands 1000, gains 128, all valids in one cycle -> mix_out 8000, mix_valid a single pulse 10 edges later.
REQ-031 SHALL cover saturation: all bands 30000 with gain 255 -> 32767; all bands -32768 with gain 255 -> -32768.
REQ-032 SHALL cover gain and rounding: band0 1000 with gain 64, other gains 0 -> 500; band0 -1 with gain 1, others 0 -> -1 (floor).
REQ-033 SHALL cover skew: bands 0-6 valid in cycle 0, band 7 valid in cycle 5 -> exactly one mix_valid, 10 edges after cycle 5; no earlier pulse.
REQ-034 SHALL cover overrun and clear-race: band 3 valid twice before the others -> overrun=1 and the second sample is used; a valid on the IDLE->MAC edge -> pending for the next mix.
REQ-035 SHALL cover reset mid-operation: rst_n low during MAC idx=4 -> mix_out=0, no mix_valid, overrun=0, and the next full strobe set mixes correctly.

Source files
------------

// File: rtl/band_mixer.sv
// Multi-band sample mixer. It captures per-band samples and, once every band
// has one pending, does a gain-weighted sequential MAC and saturates to 16 bits.

module band_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data,
  input  logic        valid,
  input  logic [7:0]  gain,
  input  logic        load,
  output logic        pending,
  output logic        ovr,
  output logic [15:0] wsample,
  output logic [7:0]  wgain
);
  logic [15:0] sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample  <= '0;
      pending <= 1'b0;
      wsample <= '0;
      wgain   <= '0;
    end else begin
      if (valid) sample <= data;
      // A fresh strobe on the load edge keeps the band pending for the next mix.
      if (valid)     pending <= 1'b1;
      else if (load) pending <= 1'b0;
      if (load) begin
        wsample <= sample;
        wgain   <= gain;
      end
    end
  end

  // On the load edge the old sample is consumed, so it is not an overrun.
  assign ovr = valid & pending & ~load;
endmodule

module band_mixer #(
  parameter int NUM_BANDS = 8,
  parameter int IDX_W     = $clog2(NUM_BANDS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BANDS*16-1:0] band_data,
  input  logic [NUM_BANDS-1:0]    band_valid,
  input  logic [NUM_BANDS*8-1:0]  band_gain,
  output logic signed [15:0]      mix_out,
  output logic                    mix_valid,
  output logic                    overrun
);
  localparam int ACC_W = 25 + $clog2(NUM_BANDS) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nxt;
  logic [NUM_BANDS-1:0]        pending, ovr;
  logic [NUM_BANDS-1:0][15:0]  wsample;
  logic [NUM_BANDS-1:0][7:0]   wgain;
  logic [IDX_W-1:0]            idx;
  logic signed [ACC_W-1:0]     acc, shifted;
  logic signed [24:0]          s_ext, g_ext, prod;
  logic signed [15:0]          sat;
  logic                        load;

  assign load = (state == IDLE) && (&pending);

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_lane
    band_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .data    (band_data[16*k +: 16]),
      .valid   (band_valid[k]),
      .gain    (band_gain[8*k +: 8]),
      .load    (load),
      .pending (pending[k]),
      .ovr     (ovr[k]),
      .wsample (wsample[k]),
      .wgain   (wgain[k])
    );
  end

  assign s_ext   = {{9{wsample[idx][15]}}, wsample[idx]};
  assign g_ext   = {17'b0, wgain[idx]};
  assign prod    = s_ext * g_ext;
  assign shifted = acc >>> 7;

  always_comb begin
    sat = shifted[15:0];
    if (shifted > SAT_MAX)      sat = 16'sh7fff;
    else if (shifted < SAT_MIN) sat = -16'sh8000;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = MAC;
      MAC:     if (idx == IDX_W'(NUM_BANDS-1)) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      idx       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= overrun | (|ovr);
      case (state)
        IDLE: if (load) begin
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          acc <= acc + {{(ACC_W-25){prod[24]}}, prod};
          idx <= idx + 1'b1;
        end
        OUT: begin
          mix_out   <= sat;
          mix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_band_mixer.sv
// Directed bench for band_mixer: unity, saturation, gain/floor, skew,
// overrun with clear race, and reset in the middle of a MAC.

module tb_band_mixer;
  localparam int NB = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NB*16-1:0]      band_data;
  logic [NB-1:0]         band_valid;
  logic [NB*8-1:0]       band_gain;
  logic signed [15:0]    mix_out;
  logic                  mix_valid;
  logic                  overrun;

  int checks = 0;
  int errors = 0;

  band_mixer #(.NUM_BANDS(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .band_data  (band_data),
    .band_valid (band_valid),
    .band_gain  (band_gain),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_band(input int k, input logic [15:0] d, input logic [7:0] g);
    band_data[16*k +: 16] = d;
    band_gain[8*k +: 8]   = g;
  endtask

  task automatic set_all(input logic [15:0] d, input logic [7:0] g);
    for (int k = 0; k < NB; k++) set_band(k, d, g);
  endtask

  task automatic strobe(input logic [NB-1:0] mask);
    band_valid = mask;
    tick();
    band_valid = '0;
  endtask

  // n_quiet edges with no strobe, then the edge that must raise mix_valid.
  task automatic wait_mix(input string tag, input int n_quiet, input int exp);
    for (int i = 0; i < n_quiet; i++) begin
      tick();
      check({tag, "_quiet"}, {31'b0, mix_valid}, 0);
    end
    tick();
    check({tag, "_valid"}, {31'b0, mix_valid}, 1);
    check({tag, "_out"}, mix_out, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    band_valid = '0;
    band_data = '0;
    band_gain = '0;
    #12;
    check("rst_out", mix_out, 0);
    check("rst_valid", {31'b0, mix_valid}, 0);
    check("rst_ovr", {31'b0, overrun}, 0);
    rst_n = 1'b1;
    tick();

    // unity: 8 x 1000 at gain 128
    set_all(16'd1000, 8'd128);
    strobe('1);
    wait_mix("unity", 9, 8000);
    tick();
    check("unity_pulse_end", {31'b0, mix_valid}, 0);
    check("unity_hold", mix_out, 8000);

    // saturation both ways
    set_all(16'd30000, 8'd255);
    strobe('1);
    wait_mix("sat_pos", 9, 32767);
    tick();
    set_all(16'h8000, 8'd255);
    strobe('1);
    wait_mix("sat_neg", 9, -32768);
    tick();

    // gain 64 on band0 only, then floor of -1/128
    set_all(16'd1000, 8'd0);
    set_band(0, 16'd1000, 8'd64);
    strobe('1);
    wait_mix("gain_half", 9, 500);
    tick();
    set_all(16'd1000, 8'd0);
    set_band(0, 16'hffff, 8'd1);
    strobe('1);
    wait_mix("floor", 9, -1);
    tick();

    // skew: band 7 arrives five cycles late
    set_all(16'd100, 8'd128);
    strobe(8'h7f);
    for (int i = 0; i < 4; i++) begin
      check("skew_early", {31'b0, mix_valid}, 0);
      tick();
    end
    strobe(8'h80);
    wait_mix("skew", 9, 800);
    tick();
    check("ovr_none", {31'b0, overrun}, 0);

    // overrun on band 3; second sample is mixed
    set_all(16'd0, 8'd128);
    set_band(3, 16'd500, 8'd128);
    strobe(8'h08);
    set_band(3, 16'd2000, 8'd128);
    strobe(8'h08);
    check("ovr_set", {31'b0, overrun}, 1);
    strobe(8'hf7);
    // clear race: full strobe set on the IDLE->MAC edge, plus gain churn mid-mix
    set_all(16'd1000, 8'd128);
    band_valid = '1;
    tick();
    band_valid = '0;
    set_all(16'd1000, 8'd0);
    tick();
    tick();
    set_all(16'd1000, 8'd128);
    wait_mix("ovr_mix", 6, 2000);
    wait_mix("race_mix", 9, 8000);
    check("ovr_sticky", {31'b0, overrun}, 1);
    tick();

    // reset during MAC at idx 4
    set_all(16'd1000, 8'd128);
    strobe('1);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #2;
    check("mid_rst_out", mix_out, 0);
    check("mid_rst_valid", {31'b0, mix_valid}, 0);
    check("mid_rst_ovr", {31'b0, overrun}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_quiet", {31'b0, mix_valid}, 0);
    end
    set_all(16'd300, 8'd128);
    strobe('1);
    wait_mix("post_rst", 9, 2400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
